// File: rtl/cocoa_head_pkg.sv
// cocoa_head: shared definitions for the instruction-fetch sequencer.
//   fs_state_e : fetch FSM state encoding (IDLE/REQ/LOAD/FAULT)
//   PC_INC     : fetch PC increment (one 32-bit instruction word)
//   CNT_W      : width of the REQ-state timeout counter (covers TIMEOUT up to 65535)
//   align_pc() : forces a byte address onto a word boundary
package cocoa_head;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_LOAD  = 2'd2,
    FS_FAULT = 2'd3
  } fs_state_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam int unsigned CNT_W  = 16;

  // Redirect targets may carry junk in the byte-offset bits; instructions
  // are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: loadable up-counter that bounds the time spent waiting for
// a memory acknowledge.
//   CLK_I     in  clock, rising edge
//   Reset_I   in  asynchronous active-low reset (count -> 0)
//   clr       in  synchronous clear, highest priority
//   en        in  count enable
//   load      in  load load_val (below clr, above en)
//   load_val  in  value loaded when load=1
//   tc        out terminal count: count == TIMEOUT-1
module fetch_timeout
  import cocoa_head::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             CLK_I,
  input  logic             Reset_I,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge CLK_I or negedge Reset_I) begin
    if (!Reset_I) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer for the multicycle MIPS-C datapath.
// Owns the fetch PC, requests a word from instruction memory with a req/ack
// handshake and pulses the IR write enable once per completed fetch.
//   CLK_I         in  clock, rising edge
//   Reset_I       in  asynchronous active-low reset
//   Start_I       in  launch next fetch (IDLE only)
//   Stall_I       in  blocks a launch from IDLE
//   Redirect_I    in  branch/jump/exception redirect (top priority)
//   RedirectPC_I  in  redirect target, bits [1:0] ignored
//   Clear_I       in  leaves FAULT, PC kept for retry
//   MemAck_I      in  memory read complete
//   MemErr_I      in  memory bus error
//   MemReq_O      out read request (high for the whole REQ state)
//   MemAddr_O     out fetch address (= PC_O)
//   IRWrite_O     out IR write enable
//   PC_O          out current fetch PC
//   FetchDone_O   out one-cycle pulse per written instruction
//   Busy_O        out state is not IDLE
//   Fault_O       out sticky fetch fault
module fetch_seq
  import cocoa_head::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        CLK_I,
  input  logic        Reset_I,
  input  logic        Start_I,
  input  logic        Stall_I,
  input  logic        Redirect_I,
  input  logic [31:0] RedirectPC_I,
  input  logic        Clear_I,
  input  logic        MemAck_I,
  input  logic        MemErr_I,
  output logic        MemReq_O,
  output logic [31:0] MemAddr_O,
  output logic        IRWrite_O,
  output logic [31:0] PC_O,
  output logic        FetchDone_O,
  output logic        Busy_O,
  output logic        Fault_O
);

  fs_state_e   state_reg;
  logic [31:0] pc_reg;
  logic        tmo_tc;
  logic        req_exit;
  logic        in_req;
  logic        load_ok;

  assign in_req   = (state_reg == FS_REQ);
  // Any of these ends the REQ state this cycle; the counter restarts from 0
  // so the next fetch gets a full TIMEOUT window.
  assign req_exit = Redirect_I | MemErr_I | MemAck_I | tmo_tc;

  fetch_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK_I    (CLK_I),
    .Reset_I  (Reset_I),
    .clr      (~in_req | req_exit),
    .en       (in_req),
    .load     (1'b0),
    .load_val ('0),
    .tc       (tmo_tc)
  );

  always_ff @(posedge CLK_I or negedge Reset_I) begin
    if (!Reset_I) begin
      state_reg <= FS_IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      unique case (state_reg)
        FS_IDLE: begin
          if (Redirect_I) begin
            pc_reg <= align_pc(RedirectPC_I);
          end else if (Start_I && !Stall_I) begin
            state_reg <= FS_REQ;
          end
        end
        FS_REQ: begin
          // Redirect aborts the request; error beats a simultaneous ack.
          if (Redirect_I) begin
            pc_reg    <= align_pc(RedirectPC_I);
            state_reg <= FS_IDLE;
          end else if (MemErr_I) begin
            state_reg <= FS_FAULT;
          end else if (MemAck_I) begin
            state_reg <= FS_LOAD;
          end else if (tmo_tc) begin
            state_reg <= FS_FAULT;
          end
        end
        FS_LOAD: begin
          pc_reg    <= Redirect_I ? align_pc(RedirectPC_I) : pc_reg + PC_INC;
          state_reg <= FS_IDLE;
        end
        FS_FAULT: begin
          if (Clear_I) begin
            state_reg <= FS_IDLE;
          end
        end
      endcase
    end
  end

  // A redirect arriving during LOAD squashes the instruction being written.
  assign load_ok     = (state_reg == FS_LOAD) & ~Redirect_I;

  assign MemReq_O    = in_req;
  assign MemAddr_O   = pc_reg;
  assign PC_O        = pc_reg;
  assign IRWrite_O   = load_ok;
  assign FetchDone_O = load_ok;
  assign Busy_O      = (state_reg != FS_IDLE);
  assign Fault_O     = (state_reg == FS_FAULT);

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: two fetch_seq instances (TIMEOUT=16 and TIMEOUT=4) share the
// same stimulus; each is compared every cycle against a behavioural model,
// with extra directed checks for the listed scenarios.
module tb_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int P_IDLE    = 0;
  localparam int P_WAIT    = 1;
  localparam int P_LOADED  = 2;
  localparam int P_FAULTED = 3;

  logic        CLK_I   = 1'b0;
  logic        Reset_I = 1'b1;
  logic        start = 0, stall = 0, redir = 0, clear = 0, ack = 0, err = 0;
  logic [31:0] rpc = '0;

  logic        a_req, a_irw, a_fd, a_busy, a_fault;
  logic [31:0] a_addr, a_pc;
  logic        b_req, b_irw, b_fd, b_busy, b_fault;
  logic [31:0] b_addr, b_pc;

  fetch_seq #(.RESET_PC(RST_PC), .TIMEOUT(16)) dut_a (
    .CLK_I(CLK_I), .Reset_I(Reset_I), .Start_I(start), .Stall_I(stall),
    .Redirect_I(redir), .RedirectPC_I(rpc), .Clear_I(clear),
    .MemAck_I(ack), .MemErr_I(err), .MemReq_O(a_req), .MemAddr_O(a_addr),
    .IRWrite_O(a_irw), .PC_O(a_pc), .FetchDone_O(a_fd), .Busy_O(a_busy),
    .Fault_O(a_fault)
  );

  fetch_seq #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut_b (
    .CLK_I(CLK_I), .Reset_I(Reset_I), .Start_I(start), .Stall_I(stall),
    .Redirect_I(redir), .RedirectPC_I(rpc), .Clear_I(clear),
    .MemAck_I(ack), .MemErr_I(err), .MemReq_O(b_req), .MemAddr_O(b_addr),
    .IRWrite_O(b_irw), .PC_O(b_pc), .FetchDone_O(b_fd), .Busy_O(b_busy),
    .Fault_O(b_fault)
  );

  always #5 CLK_I = ~CLK_I;

  int errors = 0;
  int checks = 0;

  // Reference model: phase, PC and number of REQ cycles spent so far.
  int          ph     [2];
  logic [31:0] mpc    [2];
  int          waited [2];
  int          tmo    [2] = '{16, 4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k]     = P_IDLE;
      mpc[k]    = RST_PC;
      waited[k] = 0;
    end
  endtask

  task automatic model_compare(input int k);
    logic        req_g, irw_g, fd_g, busy_g, fault_g;
    logic [31:0] addr_g, pc_g;
    string       n;
    n       = (k == 0) ? "A" : "B";
    req_g   = (k == 0) ? a_req   : b_req;
    irw_g   = (k == 0) ? a_irw   : b_irw;
    fd_g    = (k == 0) ? a_fd    : b_fd;
    busy_g  = (k == 0) ? a_busy  : b_busy;
    fault_g = (k == 0) ? a_fault : b_fault;
    addr_g  = (k == 0) ? a_addr  : b_addr;
    pc_g    = (k == 0) ? a_pc    : b_pc;
    check($sformatf("%s.req", n),   req_g,   ph[k] == P_WAIT);
    check($sformatf("%s.irw", n),   irw_g,   ph[k] == P_LOADED && !redir);
    check($sformatf("%s.done", n),  fd_g,    ph[k] == P_LOADED && !redir);
    check($sformatf("%s.busy", n),  busy_g,  ph[k] != P_IDLE);
    check($sformatf("%s.fault", n), fault_g, ph[k] == P_FAULTED);
    check($sformatf("%s.pc", n),    pc_g,    mpc[k]);
    check($sformatf("%s.addr", n),  addr_g,  mpc[k]);
  endtask

  task automatic model_step(input int k);
    case (ph[k])
      P_IDLE: begin
        if (redir) mpc[k] = rpc & ~32'd3;
        else if (start && !stall) begin
          ph[k]     = P_WAIT;
          waited[k] = 0;
        end
      end
      P_WAIT: begin
        waited[k]++;
        if (redir) begin
          mpc[k] = rpc & ~32'd3;
          ph[k]  = P_IDLE;
        end else if (err) ph[k] = P_FAULTED;
        else if (ack) ph[k] = P_LOADED;
        else if (waited[k] >= tmo[k]) ph[k] = P_FAULTED;
      end
      P_LOADED: begin
        if (redir) mpc[k] = rpc & ~32'd3;
        else begin
          $display("txn %s fetch addr=%h", (k == 0) ? "A" : "B", mpc[k]);
          mpc[k] = mpc[k] + 32'd4;
        end
        ph[k] = P_IDLE;
      end
      default: if (clear) ph[k] = P_IDLE;
    endcase
  endtask

  // look: settle then compare both DUTs to the model; adv: clock edge.
  task automatic look();
    #2;
    model_compare(0);
    model_compare(1);
  endtask

  task automatic adv();
    @(posedge CLK_I);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic tick();
    look();
    adv();
  endtask

  int nreq_a, nreq_b, nfd_a;

  initial begin
    model_reset();
    #1 Reset_I = 1'b0;
    #1;
    check("rst.req", a_req, 0);
    check("rst.pc", a_pc, RST_PC);
    check("rst.busy", a_busy, 0);
    check("rst.irw", a_irw, 0);
    check("rst.fault", b_fault, 0);
    look();
    @(posedge CLK_I);
    #1 Reset_I = 1'b1;

    // Zero-wait fetch: IRWrite two cycles after Start.
    start = 1; tick();
    start = 0; ack = 1;
    look(); check("s1.req", a_req, 1); check("s1.addr", a_addr, 32'h0); adv();
    ack = 0;
    look(); check("s1.irw", a_irw, 1); check("s1.done", a_fd, 1); adv();
    look(); check("s1.pc", a_pc, 32'h4); check("s1.irw_off", a_irw, 0); adv();

    // Ack after 5 wait cycles: A completes, B (TIMEOUT=4) faults.
    nreq_a = 0; nreq_b = 0; nfd_a = 0;
    start = 1; tick();
    start = 0;
    for (int i = 0; i < 7; i++) begin
      ack = (i == 5);
      look();
      nreq_a += int'(a_req); nreq_b += int'(b_req); nfd_a += int'(a_fd);
      adv();
    end
    ack = 0;
    look();
    check("s2.req_cycles_a", nreq_a, 6);
    check("s2.done_count_a", nfd_a, 1);
    check("s2.pc_a", a_pc, 32'h8);
    check("s2.req_cycles_b", nreq_b, 4);
    check("s2.fault_b", b_fault, 1);
    check("s2.pc_b", b_pc, 32'h4);
    adv();
    clear = 1; tick();
    clear = 0;
    look(); check("s2.clear_fault_b", b_fault, 0); check("s2.clear_busy_b", b_busy, 0); adv();

    // Redirect during REQ, late ack discarded.
    start = 1; tick();
    start = 0; redir = 1; rpc = 32'h0040_0103;
    look(); check("s3.req", a_req, 1); adv();
    redir = 0; ack = 1;
    look();
    check("s3.req_drop", a_req, 0);
    check("s3.pc", a_pc, 32'h0040_0100);
    check("s3.irw", a_irw, 0);
    adv();
    ack = 0;
    look(); check("s3.irw_late", a_irw, 0); check("s3.busy", a_busy, 0); adv();

    // Redirect coinciding with LOAD.
    start = 1; tick();
    start = 0; ack = 1; tick();
    ack = 0; redir = 1; rpc = 32'h1234_5678;
    look(); check("s3.load_irw", a_irw, 0); check("s3.load_done", a_fd, 0); adv();
    redir = 0;
    look(); check("s3.load_pc", a_pc, 32'h1234_5678); adv();

    // PC wrap at the top of the address space.
    redir = 1; rpc = 32'hFFFF_FFFE; tick();
    redir = 0; start = 1; tick();
    start = 0; ack = 1; tick();
    ack = 0;
    look(); check("s4.irw", a_irw, 1); check("s4.pc_pre", a_pc, 32'hFFFF_FFFC); adv();
    look(); check("s4.wrap_a", a_pc, 32'h0); check("s4.wrap_b", b_pc, 32'h0); adv();

    // Ack and error together -> fault; Start/Redirect ignored in FAULT.
    start = 1; tick();
    start = 0; ack = 1; err = 1; tick();
    ack = 0; err = 0; start = 1; redir = 1; rpc = 32'h0000_0100;
    look(); check("s5.fault", a_fault, 1); adv();
    start = 0; redir = 0;
    look(); check("s5.fault_held", a_fault, 1); check("s5.pc", a_pc, 32'h0); adv();
    clear = 1; tick();
    clear = 0;
    look(); check("s5.cleared", a_fault, 0); check("s5.busy", a_busy, 0); adv();

    // Asynchronous reset while in REQ.
    redir = 1; rpc = 32'h0000_0040; tick();
    redir = 0; start = 1; tick();
    start = 0;
    look(); check("s6.req", a_req, 1);
    Reset_I = 1'b0;
    #1;
    check("s6.req_drop", a_req, 0);
    check("s6.busy", a_busy, 0);
    check("s6.pc", a_pc, RST_PC);
    check("s6.pc_b", b_pc, RST_PC);
    model_reset();
    @(posedge CLK_I);
    #1 Reset_I = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(1, 0) == 1);
      stall = ($urandom_range(3, 0) == 0);
      redir = ($urandom_range(15, 0) == 0);
      clear = ($urandom_range(7, 0) == 0);
      ack   = ($urandom_range(3, 0) == 0);
      err   = ($urandom_range(31, 0) == 0);
      rpc   = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer for the multicycle MIPS-C datapath. It owns the fetch PC, issues a read request to instruction memory with a req/ack handshake, and pulses the IR write enable exactly once per completed fetch. It sits between the main control FSM (Start/Stall/Redirect) and the memory interface, and drives the IR register's write enable.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
TIMEOUT, 16, maximum number of cycles spent in REQ before a fault; legal range 2..65535.

Ports:
CLK_I  in  1  system clock, rising edge.
Reset_I  in  1  asynchronous, active-low reset.
Start_I  in  1  core requests the next fetch; sampled only in IDLE.
Stall_I  in  1  blocks a fetch launch from IDLE.
Redirect_I  in  1  branch/jump/exception redirect.
RedirectPC_I  in  32  redirect target; bits [1:0] are ignored.
Clear_I  in  1  clears a sticky fault.
MemAck_I  in  1  memory read complete; data is valid from this cycle until the next MemReq_O rise.
MemErr_I  in  1  memory bus error.
MemReq_O  out  1  read request.
MemAddr_O  out  32  fetch address; always equals PC_O.
IRWrite_O  out  1  IR write enable.
PC_O  out  32  current fetch PC.
FetchDone_O  out  1  one-cycle pulse when an instruction has been written.
Busy_O  out  1  high whenever the state is not IDLE.
Fault_O  out  1  sticky fetch fault.

Behaviour:
- Reset (Reset_I=0, asynchronous): state=IDLE, PC_O=RESET_PC, timeout counter=0. All other outputs are 0.
- States: IDLE, REQ, LOAD, FAULT. State and PC are registered; all outputs are decoded from state.
- IDLE: if Start_I=1 and Stall_I=0, go to REQ next cycle. Otherwise stay in IDLE.
- REQ:
  - MemReq_O=1, held continuously until the state is left.
  - The counter increments each cycle spent in REQ.
  - MemAck_I=1: go to LOAD.
  - MemErr_I=1, or counter==TIMEOUT-1 with no ack: go to FAULT.
  - If ack and err arrive in the same cycle, err wins.
  - The counter clears on leaving REQ.
- LOAD (exactly 1 cycle):
  - IRWrite_O = ~Redirect_I; IR captures the memory data at the end of this cycle.
  - FetchDone_O = ~Redirect_I.
  - PC_O <= PC_O + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Next state is IDLE.
  - Minimum latency from Start_I to the IRWrite_O pulse is 2 cycles (IDLE->REQ with ack in the first REQ cycle ->LOAD).
- Redirect_I=1 has top priority in IDLE, REQ and LOAD:
  - PC_O <= {RedirectPC_I[31:2],2'b00} and next state is IDLE.
  - In REQ, an outstanding request is aborted; MemReq_O is low the next cycle and any ack in that cycle is discarded.
  - In LOAD, the IR write is suppressed and the +4 does not happen.
  - Start_I in the same cycle as Redirect_I is ignored.
- FAULT: Fault_O=1 and Busy_O=1; Redirect_I and Start_I are ignored. Clear_I=1 returns to IDLE with PC_O unchanged, so the faulting address can be retried.
- MemAck_I or MemErr_I asserted outside REQ is ignored.
- Reset asserted mid-transaction drops MemReq_O immediately (asynchronously).

Decomposition:
- Shared package (cocoa_head): state encodings FS_IDLE=2'd0, FS_REQ=2'd1, FS_LOAD=2'd2, FS_FAULT=2'd3; the constant PC_INC=32'd4.
- One natural sub-module: fetch_timeout, a loadable up-counter with clear/enable and a terminal-count flag at TIMEOUT-1.
- The FSM and PC register remain in fetch_seq.

Test Plan:
- Reset release, Start_I=1, ack in the 1st REQ cycle -> MemAddr_O=0, IRWrite_O and FetchDone_O pulse high for 1 cycle 2 cycles after Start_I, PC_O=4.
- Ack after 5 wait cycles (TIMEOUT=16) -> MemReq_O held high for 6 cycles, a single IRWrite_O pulse, PC_O +4.
- No ack with TIMEOUT=4 -> FAULT after 4 REQ cycles, Fault_O=1, PC_O unchanged; Clear_I -> IDLE, Fault_O=0.
- Redirect_I with RedirectPC_I=32'h0040_0103 during REQ -> MemReq_O low next cycle, PC_O=32'h0040_0100, no IRWrite_O; redirect coinciding with LOAD -> IRWrite_O=0, PC_O=target.
- PC_O=32'hFFFF_FFFC, successful fetch -> PC_O=0; MemAck_I and MemErr_I together -> FAULT.
- Reset_I pulsed low while in REQ -> MemReq_O=0 immediately, PC_O=RESET_PC, Busy_O=0.
